plant_send_sched: RTL and testbench

//  Downstream consumer of the plant index lookup. Requests the index lookup, latches the plant's IP,

---
 rtl/plant_send_sched_pkg.sv | 31 +++
 rtl/plant_send_sched.sv | 210 +++++++++++++++++++++
 tb/tb_plant_send_sched.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plant_send_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : plant_send_sched_pkg
// Description : Shared state encodings, counter width and helpers for the
//               plant send scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package plant_send_sched_pkg;

  // Default width of the microsecond offset counter; matches the lookup's
  // time-offset field.
  localparam int SCHED_CNT_W = 32;

  // Scheduler states, explicitly 3 bits wide with fixed encodings.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT_IDX = 3'd2,
    S_ARMED    = 3'd3,
    S_WAIT_OFS = 3'd4,
    S_SEND     = 3'd5,
    S_ERROR    = 3'd6
  } sched_state_t;

  // An interval of zero means "every macrocycle", same as one.
  function automatic logic [15:0] norm_interval(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/plant_send_sched.sv
`default_nettype none
// ============================================================================
// Module      : plant_send_sched
// Description : Requests the plant index lookup, latches the plant's send
//               parameters and issues one transmit request per scheduled
//               macrocycle at a fixed microsecond offset from its start.
// Revision    : 1.0 - initial release
// ============================================================================
module plant_send_sched
  import plant_send_sched_pkg::*;
#(
  parameter int IDX_TIMEOUT = 16,
  parameter int CNT_W       = SCHED_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sched_en,
  input  logic             i_reindex,
  input  logic             i_macro_start,
  input  logic             i_us_tick,
  output logic             o_plant_index_irq,
  input  logic             i_plant_index_done,
  input  logic             i_plant_index_error,
  input  logic [31:0]      i_plant_ip,
  input  logic [CNT_W-1:0] i_plant_toffset,
  input  logic [15:0]      i_plant_datalen,
  input  logic [15:0]      i_plant_interval,
  output logic             o_send_req,
  input  logic             i_send_ack,
  output logic [31:0]      o_send_ip,
  output logic [15:0]      o_send_len,
  output logic             o_sched_valid,
  output logic             o_sched_error,
  output logic             o_missed
);

  localparam int                 c_tmo_w   = $clog2(IDX_TIMEOUT + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_lim = c_tmo_w'(IDX_TIMEOUT);

  sched_state_t       r_state,    w_state;
  logic [c_tmo_w-1:0] r_tmo,      w_tmo;
  logic [31:0]        r_ip,       w_ip;
  logic [CNT_W-1:0]   r_toffset,  w_toffset;
  logic [15:0]        r_len,      w_len;
  logic [15:0]        r_interval, w_interval;
  logic [15:0]        r_cyc,      w_cyc;
  logic [CNT_W-1:0]   r_ofs,      w_ofs;
  logic               r_send_req, w_send_req;
  logic               r_valid,    w_valid;
  logic               r_error,    w_error;
  logic               r_missed,   w_missed;

  logic [CNT_W-1:0]   w_ofs_inc;
  logic [15:0]        w_cyc_adv;
  logic               w_launch;

  // Offset counter advance (saturating) and macrocycle counter advance.
  always_comb begin
    w_ofs_inc = r_ofs;
    if (i_us_tick && (r_ofs != {CNT_W{1'b1}})) begin
      w_ofs_inc = r_ofs + CNT_W'(1);
    end
    w_cyc_adv = (r_cyc == (r_interval - 16'd1)) ? 16'd0 : (r_cyc + 16'd1);
    w_launch  = (r_cyc == 16'd0);
  end

  // Next-state and next-output logic for the scheduler.
  always_comb begin
    w_state    = r_state;
    w_tmo      = r_tmo;
    w_ip       = r_ip;
    w_toffset  = r_toffset;
    w_len      = r_len;
    w_interval = r_interval;
    w_cyc      = r_cyc;
    w_ofs      = r_ofs;
    w_send_req = r_send_req;
    w_valid    = r_valid;
    w_error    = r_error;
    w_missed   = 1'b0;

    if (!i_sched_en) begin
      // Disable outranks everything, including a re-index request.
      w_state    = S_IDLE;
      w_send_req = 1'b0;
      w_valid    = 1'b0;
      w_error    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state = S_REQ;
        end

        S_REQ: begin
          w_tmo   = '0;
          w_state = S_WAIT_IDX;
        end

        S_WAIT_IDX: begin
          // A timeout is treated as an error and both beat a coincident done.
          if (i_plant_index_error || (r_tmo == c_tmo_lim)) begin
            w_error = 1'b1;
            w_state = S_ERROR;
          end else if (i_plant_index_done) begin
            w_ip       = i_plant_ip;
            w_toffset  = i_plant_toffset;
            w_len      = i_plant_datalen;
            w_interval = norm_interval(i_plant_interval);
            w_valid    = 1'b1;
            w_cyc      = 16'd0;
            w_state    = S_ARMED;
          end else begin
            w_tmo = r_tmo + c_tmo_w'(1);
          end
        end

        S_ERROR: begin
          if (i_reindex) begin
            w_error = 1'b0;
            w_state = S_REQ;
          end
        end

        S_ARMED, S_WAIT_OFS, S_SEND: begin
          if (i_reindex) begin
            w_send_req = 1'b0;
            w_valid    = 1'b0;
            w_state    = S_REQ;
          end else begin
            // An ack retires the request, even when it lands with a macro start.
            if ((r_state == S_SEND) && i_send_ack) begin
              w_send_req = 1'b0;
              w_state    = S_ARMED;
            end
            if (i_macro_start) begin
              // Request still outstanding (or not yet issued) at the next
              // macrocycle: flag it, drop it, and still process this start.
              if ((r_state == S_WAIT_OFS) || ((r_state == S_SEND) && !i_send_ack)) begin
                w_missed = 1'b1;
              end
              w_send_req = 1'b0;
              w_cyc      = w_cyc_adv;
              w_state    = S_ARMED;
              if (w_launch) begin
                w_ofs = '0;
                if (r_toffset == '0) begin
                  w_send_req = 1'b1;
                  w_state    = S_SEND;
                end else begin
                  w_state = S_WAIT_OFS;
                end
              end
            end else if (r_state == S_WAIT_OFS) begin
              w_ofs = w_ofs_inc;
              if (w_ofs_inc == r_toffset) begin
                w_send_req = 1'b1;
                w_state    = S_SEND;
              end
            end
          end
        end

        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; asynchronous reset clears everything.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_tmo      <= '0;
      r_ip       <= '0;
      r_toffset  <= '0;
      r_len      <= '0;
      r_interval <= '0;
      r_cyc      <= '0;
      r_ofs      <= '0;
      r_send_req <= 1'b0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      r_missed   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_tmo      <= w_tmo;
      r_ip       <= w_ip;
      r_toffset  <= w_toffset;
      r_len      <= w_len;
      r_interval <= w_interval;
      r_cyc      <= w_cyc;
      r_ofs      <= w_ofs;
      r_send_req <= w_send_req;
      r_valid    <= w_valid;
      r_error    <= w_error;
      r_missed   <= w_missed;
    end
  end

  assign o_plant_index_irq = (r_state == S_REQ);
  assign o_send_req        = r_send_req;
  assign o_send_ip         = r_ip;
  assign o_send_len        = r_len;
  assign o_sched_valid     = r_valid;
  assign o_sched_error     = r_error;
  assign o_missed          = r_missed;

endmodule
`default_nettype wire

// File: tb/tb_plant_send_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_plant_send_sched
// Description : Randomised self-checking bench for plant_send_sched. The
//               stimulus process predicts irq / request / missed events from
//               the scheduling rules and queues them; a monitor pops and
//               compares whenever the DUT shows such an event.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_plant_send_sched;

  localparam int EV_IRQ  = 0;
  localparam int EV_MISS = 1;
  localparam int EV_REQ  = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_sched_en = 1'b0;
  logic        i_reindex = 1'b0;
  logic        i_macro_start = 1'b0;
  logic        i_us_tick = 1'b0;
  logic        o_plant_index_irq;
  logic        i_plant_index_done = 1'b0;
  logic        i_plant_index_error = 1'b0;
  logic [31:0] i_plant_ip = '0;
  logic [31:0] i_plant_toffset = '0;
  logic [15:0] i_plant_datalen = '0;
  logic [15:0] i_plant_interval = '0;
  logic        o_send_req;
  logic        i_send_ack = 1'b0;
  logic [31:0] o_send_ip;
  logic [15:0] o_send_len;
  logic        o_sched_valid;
  logic        o_sched_error;
  logic        o_missed;

  plant_send_sched dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_sched_en          (i_sched_en),
    .i_reindex           (i_reindex),
    .i_macro_start       (i_macro_start),
    .i_us_tick           (i_us_tick),
    .o_plant_index_irq   (o_plant_index_irq),
    .i_plant_index_done  (i_plant_index_done),
    .i_plant_index_error (i_plant_index_error),
    .i_plant_ip          (i_plant_ip),
    .i_plant_toffset     (i_plant_toffset),
    .i_plant_datalen     (i_plant_datalen),
    .i_plant_interval    (i_plant_interval),
    .o_send_req          (o_send_req),
    .i_send_ack          (i_send_ack),
    .o_send_ip           (o_send_ip),
    .o_send_len          (o_send_len),
    .o_sched_valid       (o_sched_valid),
    .o_sched_error       (o_sched_error),
    .o_missed            (o_missed)
  );

  always #5 i_clk = ~i_clk;

  // Free-running cycle number; inputs driven after posedge k belong to cycle k.
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] ip;
    logic [15:0] len;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  // Reference model state: the parameters of the current lookup and where
  // the scheduled transmission of the current macrocycle stands.
  logic [31:0] m_ip;
  logic [15:0] m_len;
  int          m_toff;
  int          m_int;
  int          m_mac;
  bit          m_pend;
  bit          m_issued;
  int          m_ticks;
  int          m_ack_at;

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.ip   = m_ip;
    e.len  = m_len;
    exp_q.push_back(e);
  endtask

  task automatic match(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event: kind %0d seen at cycle %0d, none expected", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check32("event_kind", kind, e.kind);
      check32("event_cycle", cyc, e.cyc);
      if (kind == EV_REQ) begin
        check32("send_ip", o_send_ip, e.ip);
        check32("send_len", 32'(o_send_len), 32'(e.len));
      end
    end
  endtask

  // Monitor: a request is "new" when send_req is high and the previous one
  // (if any) was retired by ack or a macro start in the cycle before.
  logic req_d = 1'b0, ack_d = 1'b0, macro_d = 1'b0;
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      req_d   <= 1'b0;
      ack_d   <= 1'b0;
      macro_d <= 1'b0;
    end else begin
      if (o_plant_index_irq) match(EV_IRQ);
      if (o_missed) match(EV_MISS);
      if (o_send_req && (!req_d || ack_d || macro_d)) match(EV_REQ);
      req_d   <= o_send_req;
      ack_d   <= i_send_ack;
      macro_d <= i_macro_start;
    end
  end

  // Advance one cycle; pulses default low, parameter inputs carry junk.
  task automatic nxt();
    @(posedge i_clk);
    #1;
    i_macro_start       = 1'b0;
    i_us_tick           = 1'b0;
    i_send_ack          = 1'b0;
    i_reindex           = 1'b0;
    i_plant_index_done  = 1'b0;
    i_plant_index_error = 1'b0;
    i_plant_ip          = $urandom;
    i_plant_toffset     = $urandom;
    i_plant_datalen     = 16'($urandom);
    i_plant_interval    = 16'($urandom);
  endtask

  // Start (enable) or restart (reindex) the lookup and answer after dly clocks.
  task automatic lookup(input bit via_reindex, input logic [31:0] ip, input int toff,
                        input logic [15:0] len, input logic [15:0] intv, input int dly);
    nxt();
    if (via_reindex) i_reindex = 1'b1;
    else             i_sched_en = 1'b1;
    push(EV_IRQ, cyc + 1);
    m_pend   = 1'b0;
    m_ack_at = -1;
    nxt();
    check1("valid_low_during_lookup", o_sched_valid, 1'b0);
    check1("req_low_during_lookup", o_send_req, 1'b0);
    repeat (dly) nxt();
    i_plant_index_done = 1'b1;
    i_plant_ip         = ip;
    i_plant_toffset    = 32'(toff);
    i_plant_datalen    = len;
    i_plant_interval   = intv;
    m_ip   = ip;
    m_len  = len;
    m_toff = toff;
    m_int  = (intv == 16'd0) ? 1 : int'(intv);
    m_mac  = 0;
    nxt();
    check1("valid_after_done", o_sched_valid, 1'b1);
    check1("error_after_done", o_sched_error, 1'b0);
    check32("ip_latched", o_send_ip, ip);
    check32("len_latched", 32'(o_send_len), 32'(len));
  endtask

  task automatic issue(input int adly);
    m_issued = 1'b1;
    push(EV_REQ, cyc + 1);
    m_ack_at = (adly < 0) ? -1 : cyc + 1 + adly;
  endtask

  // nm macrocycles of per clocks each; us ticks with probability 1/tdiv;
  // ack adly clocks after the request appears (negative: never).
  task automatic run_macros(input int nm, input int per, input int tdiv, input int adly);
    for (int k = 0; k < nm; k++) begin
      for (int p = 0; p < per; p++) begin
        nxt();
        i_us_tick = ($urandom_range(tdiv - 1, 0) == 0);
        if (p == 0) begin
          i_macro_start = 1'b1;
          if (m_pend) begin
            if (m_issued && (m_ack_at == cyc)) i_send_ack = 1'b1;
            else                               push(EV_MISS, cyc + 1);
          end
          m_pend   = 1'b0;
          m_ack_at = -1;
          if ((m_mac % m_int) == 0) begin
            m_pend   = 1'b1;
            m_issued = 1'b0;
            m_ticks  = 0;
            if (m_toff == 0) issue(adly);
          end
          m_mac++;
        end else if (m_pend) begin
          if (!m_issued) begin
            if (i_us_tick) begin
              m_ticks++;
              if (m_ticks == m_toff) issue(adly);
            end
          end else if (cyc == m_ack_at) begin
            i_send_ack = 1'b1;
            m_pend     = 1'b0;
          end
        end
      end
    end
  endtask

  // Drop the enable; everything must clear on the following clock.
  task automatic stop(input int exp_req);
    nxt();
    if (exp_req >= 0) check1("req_held_before_disable", o_send_req, exp_req[0]);
    i_sched_en = 1'b0;
    nxt();
    check1("req_after_disable", o_send_req, 1'b0);
    check1("valid_after_disable", o_sched_valid, 1'b0);
    check1("error_after_disable", o_sched_error, 1'b0);
    m_pend = 1'b0;
  endtask

  task automatic error_scenario();
    int t;
    nxt();
    i_sched_en = 1'b1;
    push(EV_IRQ, cyc + 1);
    repeat (3) nxt();
    // done and error together: error must win
    i_plant_index_error = 1'b1;
    i_plant_index_done  = 1'b1;
    nxt();
    check1("error_after_error_pulse", o_sched_error, 1'b1);
    check1("valid_after_error_pulse", o_sched_valid, 1'b0);
    for (int k = 0; k < 10; k++) begin
      nxt();
      i_macro_start = (k % 4 == 0);
      i_us_tick     = 1'b1;
    end
    nxt();
    check1("error_sticky", o_sched_error, 1'b1);
    i_reindex = 1'b1;
    t = cyc + 1;
    push(EV_IRQ, t);
    nxt();
    check1("error_cleared_by_reindex", o_sched_error, 1'b0);
    repeat (16) nxt();
    check1("no_timeout_at_16", o_sched_error, 1'b0);
    nxt();
    i_plant_index_done = 1'b1;  // one clock too late
    check1("no_timeout_at_17", o_sched_error, 1'b0);
    nxt();
    check1("timeout_error", o_sched_error, 1'b1);
    check1("valid_after_timeout", o_sched_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int per, tdiv, adly, nm, toff, dly;
    logic [15:0] intv;

    repeat (3) @(posedge i_clk);
    #1;
    check1("rst_irq", o_plant_index_irq, 1'b0);
    check1("rst_req", o_send_req, 1'b0);
    check1("rst_valid", o_sched_valid, 1'b0);
    check1("rst_error", o_sched_error, 1'b0);
    check1("rst_missed", o_missed, 1'b0);
    check32("rst_ip", o_send_ip, 32'h0);
    check32("rst_len", 32'(o_send_len), 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Basic schedule, interval 1, offset 5 ticks
    lookup(1'b0, 32'hC0A8_0105, 5, 16'h0020, 16'd1, 3);
    run_macros(4, 20, 2, 1);
    stop(-1);

    // Interval 3, immediate ack
    lookup(1'b0, 32'h0A00_0003, 2, 16'h0011, 16'd3, 5);
    run_macros(7, 12, 1, 0);
    stop(-1);

    // Lookup error, timeout, then recovery with a done exactly at the limit
    error_scenario();
    lookup(1'b1, 32'h0A00_0004, 3, 16'h0040, 16'd2, 16);
    run_macros(4, 14, 2, 2);
    stop(-1);

    // Offset 0 with ack withheld: missed every macrocycle, re-issued each time
    lookup(1'b0, 32'h0A00_0005, 0, 16'h0008, 16'd1, 2);
    run_macros(3, 8, 2, -1);
    stop(1);

    // Interval 0 acts as 1; ack coincident with the next macro start
    lookup(1'b0, 32'h0A00_0006, 0, 16'h0009, 16'd0, 4);
    run_macros(3, 10, 2, 9);
    lookup(1'b1, 32'h0A00_0007, 3, 16'h000A, 16'd0, 1);
    run_macros(3, 10, 1, 6);
    stop(-1);

    // Enable dropped while a request is held in SEND
    lookup(1'b0, 32'h0A00_0008, 2, 16'h0010, 16'd1, 4);
    run_macros(1, 12, 1, -1);
    stop(1);

    // Asynchronous reset while waiting for the offset, then restart
    lookup(1'b0, 32'h0A00_0009, 40, 16'h0030, 16'd1, 2);
    run_macros(1, 10, 1, -1);
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    check1("async_rst_req", o_send_req, 1'b0);
    check1("async_rst_valid", o_sched_valid, 1'b0);
    check1("async_rst_irq", o_plant_index_irq, 1'b0);
    check32("async_rst_ip", o_send_ip, 32'h0);
    i_sched_en = 1'b0;
    m_pend     = 1'b0;
    #2;
    i_rst_n = 1'b1;
    lookup(1'b0, 32'h0A00_000A, 1, 16'h0031, 16'd1, 3);
    run_macros(2, 10, 1, 1);
    stop(-1);

    // Randomised schedules
    for (int it = 0; it < 8; it++) begin
      per  = $urandom_range(24, 8);
      tdiv = $urandom_range(3, 1);
      adly = ($urandom_range(3, 0) == 0) ? -1 : int'($urandom_range(per, 0));
      nm   = $urandom_range(7, 3);
      toff = $urandom_range(6, 0);
      dly  = $urandom_range(16, 1);
      intv = 16'($urandom_range(3, 0));
      lookup(1'b0, $urandom, toff, 16'($urandom), intv, dly);
      run_macros(nm, per, tdiv, adly);
      stop(-1);
    end

    repeat (5) nxt();
    check32("expected_events_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
